parity_serial_tx: RTL and testbench
===================================

# parity_serial_tx

Serial frame transmitter that generates and appends a configurable even/odd parity bit to each data word. Transmit-side counterpart of `parity_checker`: a word accepted over a valid/ready handshake is sent LSB-first as start, data, parity and stop bits on a single line. The receiving end recovers the word and parity bit and feeds them to `parity_checker` with the same `even_odd` setting.

## Interface
Parameters:
- `DATA_W`, 8: data word width; legal range 1–16.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; must be ≥ 1.

Ports:
- `clk` input 1: single clock. All logic is rising-edge.
- `rst_n` input 1: synchronous, active-low reset.
- `data_in` input `DATA_W`: word to transmit; sampled on accept.
- `even_odd` input 1: parity mode; 0 = even, 1 = odd. Sampled on accept.
- `valid_in` input 1: `data_in` and `even_odd` are valid.
- `ready_out` output 1: block can accept a word.
- `tx` output 1: serial line; idles high.
- `busy` output 1: a frame is in progress.
- `frame_done` output 1: one-cycle pulse at the end of each frame.

## Operation
- **Accept:** a word is accepted on a rising edge where `valid_in && ready_out`. The block registers `data_in` and the parity bit on that edge.
  - Parity bit = `^data_in ^ even_odd`.
  - Even mode makes the total count of ones across data and parity even; odd mode makes it odd.
- **State machine:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: `tx`=1, `ready_out`=1, `busy`=0.
  - START: `tx`=0.
  - DATA: `tx` = shift-register LSB. The register shifts right once per bit period. The state holds for `DATA_W` bit periods, tracked by a bit counter of width `$clog2(DATA_W+1)`.
  - PARITY: `tx` = registered parity bit.
  - STOP: `tx`=1.
- **Bit period:** every non-IDLE state holds `tx` for exactly `CLKS_PER_BIT` cycles. A cycle counter runs from 0 to `CLKS_PER_BIT-1`, and the state advances when it wraps.
- **Outputs in non-IDLE states:** `ready_out`=0 and `busy`=1. `valid_in` is ignored while not in IDLE, so a held `valid_in` does not queue a word.
- **`frame_done`:** asserted during the final cycle of STOP only.
- **Back-to-back frames:** after STOP the block spends one cycle in IDLE, which is the earliest accept point. The minimum inter-frame idle on `tx` is therefore 1 cycle.
- **Reset:** `rst_n`=0 on any edge forces IDLE, clears both counters and the shift register, and aborts any frame in progress. Outputs return to reset values on that same edge.

## Timing
- **Reset values:** `tx`=1, `ready_out`=1, `busy`=0, `frame_done`=0.
- **Output registration:** all outputs are registered, with no combinational path from inputs to outputs.
- **Start latency:** the edge that accepts a word drives `tx`=0 starting in the next cycle.
- **Frame length:** `(DATA_W+3)*CLKS_PER_BIT` cycles from the first START cycle through the last STOP cycle. With the defaults this is 44 cycles.
- **Bit windows:** data bit *i* is on `tx` during cycles `(1+i)*CLKS_PER_BIT` to `(2+i)*CLKS_PER_BIT-1`, counted from the first START cycle. Parity follows immediately.
- **`CLKS_PER_BIT`=1:** each bit lasts one cycle, and the counter is constant 0.
- **`ready_out` timing:** rises on the edge that leaves STOP.
- **Simultaneous reset and `valid_in`:** reset wins and no word is accepted.

## Structure
- **Shared package `parity_pkg`:**
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Constants `PARITY_EVEN`=1'b0 and `PARITY_ODD`=1'b1.
  - Constants `TX_IDLE`=1'b1, `TX_START`=1'b0 and `TX_STOP`=1'b1.
  - `parity_checker` benches reuse the same package.
- **Sub-module `bit_period_cnt`:** parameterised by `CLKS_PER_BIT`. Inputs are clock, reset and a clear. The only output is `tick`, a one-cycle pulse on the last cycle of each period.
  - The receive side reuses it.
  - The FSM, bit counter and shift register stay in the top module.

## Test plan
- **Even, 0xAA:** defaults, `data_in`=0xAA, `even_odd`=0.
  - `tx` bit sequence (4 cycles each): 0, 0,1,0,1,0,1,0,1, 0, 1.
  - `frame_done` pulses at cycle 43 after the first START cycle.
- **Odd, 0xAA:** `data_in`=0xAA, `even_odd`=1.
  - Same sequence, but the parity bit is 1.
- **Even, 0x07:** `data_in`=0x07, `even_odd`=0.
  - Data bits are 1,1,1,0,0,0,0,0 and parity is 1.
- **Handshake:** hold `valid_in`=1 with 0x55 then 0x0F.
  - Only 0x55 is accepted first.
  - `ready_out`=0 for 44 cycles.
  - 0x0F is accepted on the single IDLE cycle, and its start bit follows.
- **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3.
  - Next cycle: `tx`=1, `ready_out`=1, `busy`=0.
  - A new word is then sent as a complete frame.
- **Loopback:** sample `tx` at mid-bit and feed the recovered data and parity into `parity_checker` with a matching `even_odd`.
  - Over 256 words × 2 modes, `error`=0 throughout.
  - Flipping the recovered parity bit gives `error`=1.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity serial transmit/receive blocks: FSM
// states, parity mode encodings and serial line levels.
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam logic TX_IDLE  = 1'b1;
  localparam logic TX_START = 1'b0;
  localparam logic TX_STOP  = 1'b1;

endpackage

// File: rtl/bit_period_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick (registered)
// on the last cycle of every period. Held at zero while clear is high.
module bit_period_cnt #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // NOTE: every always_comb output gets a value on every path (here via the
  // if/else); a missing assignment would infer a latch.
  always_comb begin
    if (clear || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Tick is registered from the next count so it lines up with cnt == LAST.
    tick_d = (cnt_d == LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together on the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB-first, even/odd
// parity bit, stop bit. Words are accepted over a valid/ready handshake.
module parity_serial_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              even_odd,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BIT_CNT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  tick;

  bit_period_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_period_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          state_d   = START;
          shift_d   = data_in;
          parity_d  = ^data_in ^ even_odd;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) state_d = PARITY;
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode flops only, so no input reaches an output combinationally.
  always_comb begin
    tx         = TX_IDLE;
    ready_out  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        busy      = 1'b0;
      end
      START:   tx = TX_START;
      DATA:    tx = shift_q[0];
      PARITY:  tx = parity_q;
      STOP: begin
        tx         = TX_STOP;
        frame_done = tick;
      end
      default: tx = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: frame timing, handshake, reset cases
// and a loopback parity check over all words in both parity modes.
module tb_parity_serial_tx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
  localparam int FRAME  = (DATA_W + 3) * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       even_odd;
  logic       valid_in;
  logic       ready_out;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  parity_serial_tx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .even_odd  (even_odd),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a word from a negedge and holds it until the accepting edge.
  task automatic send_word(input logic [7:0] d, input logic eo);
    int waited = 0;
    @(negedge clk);
    data_in  = d;
    even_odd = eo;
    valid_in = 1'b1;
    while (ready_out !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("send_ready", {31'd0, ready_out}, 32'd1);
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  // Samples one whole frame at negedges, starting right after the accept edge.
  task automatic capture_frame(input logic [10:0] exp_frame, output logic [10:0] rec,
                               output int tx_bad, output int fd_count, output int fd_cycle,
                               output int ready_low, output int busy_high);
    rec = '0; tx_bad = 0; fd_count = 0; fd_cycle = -1; ready_low = 0; busy_high = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k % CPB == CPB / 2) rec[k/CPB] = tx;
      if (tx !== exp_frame[k/CPB]) tx_bad++;
      if (frame_done === 1'b1) begin
        fd_count++;
        fd_cycle = k;
      end
      if (ready_out === 1'b0) ready_low++;
      if (busy === 1'b1) busy_high++;
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d, input logic par);
    logic [10:0] rec;
    int tx_bad, fd_count, fd_cycle, ready_low, busy_high;
    capture_frame({1'b1, par, d, 1'b0}, rec, tx_bad, fd_count, fd_cycle, ready_low, busy_high);
    check({tag, "_start"},     {31'd0, rec[0]}, 32'd0);
    check({tag, "_data"},      {24'd0, rec[8:1]}, {24'd0, d});
    check({tag, "_parity"},    {31'd0, rec[9]}, {31'd0, par});
    check({tag, "_stop"},      {31'd0, rec[10]}, 32'd1);
    check({tag, "_tx_window"}, tx_bad, 0);
    check({tag, "_fd_count"},  fd_count, 1);
    check({tag, "_fd_cycle"},  fd_cycle, 43);
    check({tag, "_ready_low"}, ready_low, 44);
    check({tag, "_busy_high"}, busy_high, 44);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"},    {31'd0, tx}, 32'd1);
    check({tag, "_ready"}, {31'd0, ready_out}, 32'd1);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_fd"},    {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    logic [10:0] rec;
    int tx_bad, fd_count, fd_cycle, ready_low, busy_high;
    int lb_err, lb_flip_bad, lb_data_bad, lb_frame_bad;
    logic par;

    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; even_odd = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    send_word(8'hAA, 1'b0);
    check_frame("even_aa", 8'hAA, 1'b0);
    @(negedge clk);
    check_idle("even_aa_idle");

    send_word(8'hAA, 1'b1);
    check_frame("odd_aa", 8'hAA, 1'b1);

    send_word(8'h07, 1'b0);
    check_frame("even_07", 8'h07, 1'b1);

    // Held valid: 0x55 accepted, 0x0F waits for the single IDLE cycle.
    @(negedge clk);
    @(negedge clk);
    data_in = 8'h55; even_odd = 1'b0; valid_in = 1'b1;
    @(posedge clk);
    #1 data_in = 8'h0F;
    check_frame("hs_55", 8'h55, 1'b0);
    @(negedge clk);
    check("hs_idle_ready", {31'd0, ready_out}, 32'd1);
    @(posedge clk);
    #1 valid_in = 1'b0;
    check_frame("hs_0f", 8'h0F, 1'b0);
    @(negedge clk);
    check_idle("hs_idle");

    // Reset and valid on the same edge: reset wins.
    @(negedge clk);
    rst_n = 1'b0; valid_in = 1'b1; data_in = 8'hFF;
    @(posedge clk);
    #1 rst_n = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    check_idle("rst_vs_valid");
    @(negedge clk);
    check("rst_vs_valid_busy_later", {31'd0, busy}, 32'd0);

    // Reset during data bit 3 (cycles 16..19 after the first START cycle).
    send_word(8'h33, 1'b0);
    repeat (18) @(negedge clk);
    check("mid_bit3_tx", {31'd0, tx}, 32'd0);
    check("mid_bit3_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    send_word(8'h81, 1'b1);
    check_frame("after_reset_81_odd", 8'h81, 1'b1);

    lb_err = 0; lb_flip_bad = 0; lb_data_bad = 0; lb_frame_bad = 0;
    for (int mode = 0; mode < 2; mode++) begin
      for (int w = 0; w < 256; w++) begin
        send_word(w[7:0], mode[0]);
        par = ^w[7:0] ^ mode[0];
        capture_frame({1'b1, par, w[7:0], 1'b0}, rec, tx_bad, fd_count, fd_cycle,
                      ready_low, busy_high);
        if ((^rec[8:1] ^ rec[9] ^ mode[0]) !== 1'b0) lb_err++;
        if ((^rec[8:1] ^ ~rec[9] ^ mode[0]) !== 1'b1) lb_flip_bad++;
        if (rec[8:1] !== w[7:0]) lb_data_bad++;
        if (tx_bad != 0 || fd_count != 1 || fd_cycle != 43 || rec[0] !== 1'b0 || rec[10] !== 1'b1)
          lb_frame_bad++;
      end
    end
    check("loopback_error", lb_err, 0);
    check("loopback_flip_error", lb_flip_bad, 0);
    check("loopback_data", lb_data_bad, 0);
    check("loopback_frame", lb_frame_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
